// File: rtl/multicycle_control_if.sv
// multicycle_control_if: sequencer-facing bus bundling datapath controls, memory handshake and status
// master: the sequencer (drives controls/mem_req, reads opcode/flags/mem_ready)
// slave:  the datapath/memory side (drives opcode/flags/mem_ready, reads controls)
interface multicycle_control_if #(
    parameter int RETIRE_W = 32
);
    logic                start;
    logic [6:0]          opcode;
    logic                inv_func;
    logic                alu_zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic                reg_write;
    logic                mem_to_reg;
    logic                trap;
    logic [3:0]          state;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  start, opcode, inv_func, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, mem_to_reg, trap, state, retired
    );

    modport slave (
        output start, opcode, inv_func, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, mem_to_reg, trap, state, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencer for the multi-cycle RV32 subset core (ADD/SUB/OR/AND, LW, SW, BEQ)
// clk/reset: rising-edge clock, asynchronous active-high reset
// bus (master): start/opcode/inv_func/alu_zero/mem_ready in; datapath selects, memory
// request, trap, debug state and retired-instruction count out
module multicycle_control #(
    parameter logic [6:0] OP_R      = 7'b0110011,
    parameter logic [6:0] OP_LOAD   = 7'b0000011,
    parameter logic [6:0] OP_STORE  = 7'b0100011,
    parameter logic [6:0] OP_BRANCH = 7'b1100011,
    parameter int         RETIRE_W  = 32
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    state_t              state_q, state_d;
    logic                inc;
    logic [RETIRE_W-1:0] retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= inc ? retired_q + 1'b1 : retired_q;
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;

    always_comb begin
        state_d        = state_q;
        inc            = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.trap       = 1'b0;
        case (state_q)
            IDLE: state_d = bus.start ? FETCH : IDLE;
            FETCH: begin
                // PC+4 computed on the ALU while the instruction is read
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // speculative branch target lands in ALUOut
                bus.alu_src_b = 2'b11;
                state_d = (bus.opcode == OP_R) ? EXEC :
                          (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? MEM_ADDR :
                          (bus.opcode == OP_BRANCH) ? BRANCH : TRAP;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = bus.inv_func ? TRAP : R_WB;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                inc           = 1'b1;
                state_d       = FETCH;
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                state_d     = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                inc            = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
                inc         = bus.mem_ready;
                state_d     = bus.mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                // rs1-rs2 compare; taken branch loads the target held in ALUOut
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 1'b1;
                bus.pc_write  = bus.alu_zero;
                inc           = 1'b1;
                state_d       = FETCH;
            end
            TRAP: bus.trap = 1'b1;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencer for the multi-cycle RV32 subset core (R-type ADD/SUB/OR/AND, LW, SW, BEQ). It walks the shared ALU, register file and unified memory through fetch/decode/execute/memory/write-back. Per state it drives the ALU operand selects and the 2-bit alu_op consumed by the ALU-control decoder, and it handshakes with memory. It traps on an illegal opcode or an invalid-function flag and counts retired instructions.

Parameters:
OP_R, 7'b0110011, R-type opcode
OP_LOAD, 7'b0000011, LW opcode
OP_STORE, 7'b0100011, SW opcode
OP_BRANCH, 7'b1100011, BEQ opcode
RETIRE_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  leave IDLE, begin fetching
opcode  in  7  instruction register bits [6:0]
inv_func  in  1  invalid-function flag from ALU control decoder
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write enable, valid with mem_req
iord  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
alu_src_a  out  1  0=PC, 1=rs1
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm, 11=branch offset
alu_op  out  2  00=add, 01=sub, 10=funct decode
reg_write  out  1  register file write
mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR
trap  out  1  sticky fault indicator
state  out  4  current state, for debug
retired  out  RETIRE_W  retired-instruction count

Behaviour:
- Reset, asynchronous: state=IDLE(0), retired=0, trap=0. Every control output is 0 in IDLE.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, R_WB 8, BRANCH 9, TRAP 10.
- Outputs are decoded from the current state, plus the listed qualifying inputs. Any output not listed for a state is 0.
- IDLE: waits for start=1, then goes to FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - mem_ready=1: ir_write=1 and pc_write=1 (PC+4) in the same cycle; next state DECODE.
  - Otherwise hold FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - OP_R goes to EXEC; OP_LOAD or OP_STORE goes to MEM_ADDR; OP_BRANCH goes to BRANCH.
  - Any other opcode goes to TRAP.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is TRAP if inv_func=1, otherwise R_WB.
- R_WB: reg_write=1, mem_to_reg=0; retired increments; next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD if opcode==OP_LOAD, otherwise MEM_WR.
- MEM_RD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1; retired increments; next state FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: retired increments and next state is FETCH; otherwise hold.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=alu_zero. Retired increments; next state FETCH.
- TRAP: trap=1 and no other output is asserted. Only reset exits TRAP; start is ignored.
- Memory handshake:
  - mem_ready is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored in all other states.
  - mem_req and its address/we stay stable until mem_ready.
  - Waits are unbounded and add no timeout.
- Opcode and inv_func are sampled only in DECODE, EXEC and MEM_ADDR. The IR is stable from DECODE until the next FETCH completes.
- CPI: R-type 4, LW 5, SW 4, BEQ 3, each with zero wait states; every memory wait cycle adds 1.
- retired wraps modulo 2^RETIRE_W and never saturates.
- start is ignored outside IDLE.
- Reset asserted mid-instruction returns to IDLE immediately: outputs go to 0 combinationally on reset assertion, and retired and trap are cleared.

Test Plan:
- Reset, then start=1 with opcode=0110011, inv_func=0, mem_ready=1 always -> states 1,2,3,8,1. In EXEC alu_op=10; in R_WB reg_write=1; retired goes 0->1 after R_WB. CPI=4.
- LW (0000011) with mem_ready low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles with iord=1 and mem_req=1 held. MEM_WB drives mem_to_reg=1. Instruction takes 7 cycles.
- SW (0100011) -> MEM_WR drives mem_we=1; reg_write is never asserted; retired +1.
- BEQ (1100011): alu_zero=1 -> BRANCH drives pc_write=1 with pc_src=1; repeat with alu_zero=0 -> pc_write=0. Both cases take 3 cycles and add retired +1.
- Opcode 0010011 in DECODE -> TRAP(10), trap=1. Further start pulses and mem_ready are ignored. Reset -> IDLE with trap=0.
- R-type with inv_func=1 -> EXEC goes to TRAP with no reg_write. Separately, reset asserted in the middle of FETCH wait -> all outputs 0 immediately and retired=0.
